// File: rtl/spi_calc_periph.sv
// SPI mode-0 register peripheral fronting an external calculation unit.
// Optional: define SPI_CALC_AUTOSTART_EN so that a committed OPB write also requests a start.
module spi_calc_periph #(
  parameter int OP_W   = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              calc_rst_o,
  output logic              start_o,
  output logic [OP_W-1:0]   op_a_o,
  output logic [OP_W-1:0]   op_b_o,
  input  logic [2*OP_W-1:0] y_i,
  input  logic              busy_i
);

  localparam int DATA_W = 2 * OP_W;
  localparam int IDX_W  = ADDR_W - 1;
  localparam int CNT_W  = $clog2((DATA_W > ADDR_W ? DATA_W : ADDR_W) + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_OPA    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_OPB    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_RESULT = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(4);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;

  state_t              state;
  logic [1:0]          sclk_p0, cs_p0, mosi_p0;
  logic                sclk_p1;
  logic                armed;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   addr_sh;
  logic [OP_W-1:0]     data_sh;
  logic [DATA_W-1:0]   tx_sh;
  logic                miso_q;
  logic                wr_vld_p1, ld_vld_p1;
  logic [DATA_W-1:0]   result_q;
  logic                done_q, ovr_q, busy_d;
  logic [DATA_W-1:0]   rd_data;

  logic                sclk_rise, sclk_fall, cs_hi;
  logic [IDX_W-1:0]    idx;
  logic                wr_flag, auto_req, start_req, rst_eff, start_go, ovr_set, busy_fall;
  logic                clr_done, clr_ovr;

  assign sclk_rise = sclk_p0[1] & ~sclk_p1;
  assign sclk_fall = ~sclk_p0[1] & sclk_p1;
  assign cs_hi     = cs_p0[1];
  assign idx       = addr_sh[IDX_W-1:0];
  assign wr_flag   = addr_sh[ADDR_W-1];
  assign miso_o    = miso_q;

  // Frame engine: synchronisers, bit counting, receive and transmit shifters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_p0   <= '0;
      cs_p0     <= '0;
      mosi_p0   <= '0;
      sclk_p1   <= 1'b0;
      state     <= IDLE;
      armed     <= 1'b0;
      bit_cnt   <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      tx_sh     <= '0;
      miso_q    <= 1'b0;
      wr_vld_p1 <= 1'b0;
      ld_vld_p1 <= 1'b0;
    end else begin
      sclk_p0   <= {sclk_p0[0], sclk_i};
      cs_p0     <= {cs_p0[0], cs_n_i};
      mosi_p0   <= {mosi_p0[0], mosi_i};
      sclk_p1   <= sclk_p0[1];
      wr_vld_p1 <= 1'b0;
      ld_vld_p1 <= 1'b0;
      // A frame only starts after cs has been seen high, so a reset mid-frame stays idle
      if (cs_hi) begin
        state   <= IDLE;
        armed   <= 1'b1;
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (armed) begin
            state   <= ADDR;
            armed   <= 1'b0;
            bit_cnt <= '0;
          end
          ADDR: if (sclk_rise) begin
            addr_sh <= {addr_sh[ADDR_W-2:0], mosi_p0[1]};
            if (bit_cnt == ADDR_LAST) begin
              state     <= DATA;
              bit_cnt   <= '0;
              ld_vld_p1 <= ~addr_sh[ADDR_W-2];
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          DATA: if (sclk_rise) begin
            data_sh <= {data_sh[OP_W-2:0], mosi_p0[1]};
            if (bit_cnt == DATA_LAST) begin
              state     <= WAIT;
              wr_vld_p1 <= wr_flag;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
        if ((state == DATA || state == WAIT) && sclk_fall && !wr_flag) begin
          miso_q <= tx_sh[DATA_W-1];
          tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
        end
        if (ld_vld_p1) tx_sh <= rd_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      IDX_CTRL:   rd_data = {{(DATA_W-1){1'b0}}, calc_rst_o};
      IDX_OPA:    rd_data = {{OP_W{1'b0}}, op_a_o};
      IDX_OPB:    rd_data = {{OP_W{1'b0}}, op_b_o};
      IDX_RESULT: rd_data = result_q;
      IDX_STATUS: rd_data = {{(DATA_W-3){1'b0}}, ovr_q, done_q, busy_i};
      default:    rd_data = '0;
    endcase
  end

`ifdef SPI_CALC_AUTOSTART_EN
  assign auto_req = wr_vld_p1 && (idx == IDX_OPB);
`else
  assign auto_req = 1'b0;
`endif

  // A CTRL write that also changes the reset level is judged on the new level
  assign start_req = (wr_vld_p1 && (idx == IDX_CTRL) && data_sh[1]) || auto_req;
  assign rst_eff   = (wr_vld_p1 && (idx == IDX_CTRL)) ? data_sh[0] : calc_rst_o;
  assign start_go  = start_req && !busy_i && !rst_eff;
  assign ovr_set   = start_req && busy_i;
  assign busy_fall = busy_d && !busy_i;
  assign clr_done  = wr_vld_p1 && (idx == IDX_STATUS) && data_sh[1];
  assign clr_ovr   = wr_vld_p1 && (idx == IDX_STATUS) && data_sh[2];

  // Commit stage: register writes, start pulse and status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      calc_rst_o <= 1'b0;
      start_o    <= 1'b0;
      op_a_o     <= '0;
      op_b_o     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_d     <= 1'b0;
    end else begin
      busy_d  <= busy_i;
      start_o <= start_go;
      if (wr_vld_p1) begin
        case (idx)
          IDX_CTRL: calc_rst_o <= data_sh[0];
          IDX_OPA:  op_a_o     <= data_sh;
          IDX_OPB:  op_b_o     <= data_sh;
          default: ;
        endcase
      end
      if (busy_fall) result_q <= y_i;
      done_q <= (done_q & ~clr_done) | busy_fall;
      ovr_q  <= (ovr_q & ~clr_ovr) | ovr_set;
    end
  end

endmodule

// File: tb/tb_spi_calc_periph.sv
// Bench for spi_calc_periph: SPI master tasks, vector table and hand-written corner sequences.
module tb_spi_calc_periph;
  logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, busy = 1'b0;
  logic [15:0] y = '0;
  logic        miso, calc_rst, start;
  logic [7:0]  op_a, op_b;

  spi_calc_periph #(.OP_W(8), .ADDR_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso), .calc_rst_o(calc_rst), .start_o(start),
    .op_a_o(op_a), .op_b_o(op_b), .y_i(y), .busy_i(busy)
  );

  always #5 clk = ~clk;

`ifdef SPI_CALC_AUTOSTART_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  int errors = 0, checks = 0;
  int st_cnt = 0, st_hi = 0;
  logic st_prev = 1'b0;
  logic [7:0] st_a = '0, st_b = '0;

  // Start pulse monitor: counts rising edges and high cycles, captures operands
  always @(negedge clk) begin
    if (start) begin
      st_hi <= st_hi + 1;
      if (!st_prev) begin
        st_cnt <= st_cnt + 1;
        st_a   <= op_a;
        st_b   <= op_b;
      end
    end
    st_prev <= start;
  end

  typedef struct { string nm; logic [15:0] v; } exp_t;
  exp_t sb[$];

  typedef struct { logic [6:0] idx; logic [15:0] wd; logic [15:0] exp; string nm; } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] a, input logic [15:0] d, input int nbits,
                          input int rst_at, output logic [15:0] rd);
    logic [23:0] fr;
    fr = {a, d};
    rd = '0;
    cs_n = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      mosi = fr[23-i];
      #80;
      if (i >= 8) rd = {rd[14:0], miso};
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
      if (i == rst_at) begin
        #20 rst = 1'b1;
        #20 rst = 1'b0;
        #5;
        chk("rst_miso", {31'b0, miso}, 32'h0);
        chk("rst_opa", {24'b0, op_a}, 32'h0);
        chk("rst_opb", {24'b0, op_b}, 32'h0);
        chk("rst_calc_rst", {31'b0, calc_rst}, 32'h0);
      end
    end
    #80 cs_n = 1'b1;
    mosi = 1'b0;
    #200;
  endtask

  task automatic wr(input logic [6:0] idx, input logic [15:0] d);
    logic [15:0] r;
    spi_xfer({1'b1, idx}, d, 24, -1, r);
  endtask

  task automatic rd_chk(input logic [6:0] idx, input string nm, input logic [15:0] exp);
    logic [15:0] r;
    exp_t e;
    sb.push_back('{nm, exp});
    spi_xfer({1'b0, idx}, 16'h0, 24, -1, r);
    e = sb.pop_front();
    chk(e.nm, {16'b0, r}, {16'b0, e.v});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base, hbase;
    logic [15:0] r;
    tbl[0] = '{7'd1,   16'h00A5, 16'h00A5, "opa_a5"};
    tbl[1] = '{7'd1,   16'hFF3C, 16'h003C, "opa_trunc"};
    tbl[2] = '{7'd2,   16'h1281, 16'h0081, "opb_trunc"};
    tbl[3] = '{7'd0,   16'h0001, 16'h0001, "ctrl_rst1"};
    tbl[4] = '{7'd0,   16'h0000, 16'h0000, "ctrl_rst0"};
    tbl[5] = '{7'd3,   16'hBEEF, 16'h0000, "result_ro"};
    tbl[6] = '{7'd5,   16'h1234, 16'h0000, "unmapped5"};
    tbl[7] = '{7'd127, 16'hFFFF, 16'h0000, "unmapped7f"};
    tbl[8] = '{7'd4,   16'h0006, 16'h0000, "status_w1c"};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #200;
    chk("reset_miso", {31'b0, miso}, 32'h0);
    chk("reset_start", {31'b0, start}, 32'h0);
    chk("reset_calc_rst", {31'b0, calc_rst}, 32'h0);
    chk("reset_opa", {24'b0, op_a}, 32'h0);
    chk("reset_opb", {24'b0, op_b}, 32'h0);
    rd_chk(7'd4, "reset_status", 16'h0000);

    for (int i = 0; i < 9; i++) begin
      wr(tbl[i].idx, tbl[i].wd);
      rd_chk(tbl[i].idx, tbl[i].nm, tbl[i].exp);
      if (tbl[i].idx == 7'd0) chk({tbl[i].nm, "_pin"}, {31'b0, calc_rst}, {31'b0, tbl[i].exp[0]});
    end

    // Start with operands
    wr(7'd1, 16'h0012);
    wr(7'd2, 16'h0034);
    base = st_cnt; hbase = st_hi;
    wr(7'd0, 16'h0002);
    chk("start_pulses", st_cnt - base, 1);
    chk("start_width", st_hi - hbase, 1);
    chk("start_opa", {24'b0, st_a}, 32'h12);
    chk("start_opb", {24'b0, st_b}, 32'h34);
    rd_chk(7'd0, "ctrl_selfclear", 16'h0000);

    // Result capture on busy falling edge
    @(negedge clk); busy = 1'b1; y = 16'h03A8;
    repeat (3) @(negedge clk); busy = 1'b0;
    repeat (2) @(negedge clk); y = 16'h1111;
    rd_chk(7'd3, "result", 16'h03A8);
    rd_chk(7'd4, "status_done", 16'h0002);
    wr(7'd4, 16'h0002);
    rd_chk(7'd4, "status_done_clr", 16'h0000);

    // Start while busy
    @(negedge clk); busy = 1'b1;
    base = st_cnt;
    wr(7'd0, 16'h0002);
    chk("busy_no_start", st_cnt - base, 0);
    rd_chk(7'd4, "status_ovr", 16'h0005);
    wr(7'd4, 16'h0004);
    rd_chk(7'd4, "status_ovr_clr", 16'h0001);
    @(negedge clk); busy = 1'b0;
    repeat (2) @(negedge clk);
    wr(7'd4, 16'h0002);

    // Aborted write then a full frame
    spi_xfer({1'b1, 7'd1}, 16'h00FF, 12, -1, r);
    rd_chk(7'd1, "opa_abort", 16'h0012);
    wr(7'd1, 16'h0077);
    rd_chk(7'd1, "opa_after_abort", 16'h0077);

    // Reset in the middle of a read frame
    spi_xfer({1'b0, 7'd1}, 16'h0, 16, 12, r);
    rd_chk(7'd1, "opa_after_rst", 16'h0000);
    rd_chk(7'd4, "status_after_rst", 16'h0000);

    // OPB write start side effect depends on build option
    base = st_cnt;
    wr(7'd2, 16'h0005);
    chk("opb_autostart", st_cnt - base, AUTO);
    rd_chk(7'd2, "opb_05", 16'h0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
